// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//   Pulls bytes out of the UART RX FIFO and finds framed packets:
//     HDR0, HDR1, LEN, LEN payload bytes, CHK
//   CHK is the 8-bit wrapping sum of LEN and the payload bytes.
//   Payload bytes are streamed out before the checksum is known, so the
//   consumer must drop what it buffered if Err_Chk or Err_Tmo follows.
//
// Ports
//   CLK, RST     clock, asynchronous active-high reset
//   Empty_sig    RX FIFO empty
//   FIFO_RD_Dat  RX FIFO read data, valid the cycle after RD_Req_sig
//   RD_Req_sig   FIFO pop request (registered, at most every other cycle)
//   Pay_Dat      payload byte
//   Pay_Idx      payload byte index, 0-based
//   Pay_Vld      strobe for Pay_Dat / Pay_Idx
//   Frame_Len    LEN of the last good frame
//   Frame_Done   pulse: frame complete, checksum good
//   Err_Chk      pulse: checksum mismatch
//   Err_Len      pulse: LEN == 0 or LEN > MAX_LEN
//   Err_Tmo      pulse: inter-byte timeout inside a frame
module uart_rx_frame_parser #(
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55,
  parameter int         MAX_LEN     = 32,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Empty_sig,
  input  logic [7:0] FIFO_RD_Dat,
  output logic       RD_Req_sig,
  output logic [7:0] Pay_Dat,
  output logic [5:0] Pay_Idx,
  output logic       Pay_Vld,
  output logic [7:0] Frame_Len,
  output logic       Frame_Done,
  output logic       Err_Chk,
  output logic       Err_Len,
  output logic       Err_Tmo
);

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LEN,
    S_PAY,
    S_CHK
  } state_t;

  state_t        state;
  logic          cap;      // FIFO_RD_Dat holds a freshly popped byte this cycle
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [5:0]    idx;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_HDR0;
      cap        <= 1'b0;
      len        <= '0;
      sum        <= '0;
      idx        <= '0;
      tmo_cnt    <= '0;
      RD_Req_sig <= 1'b0;
      Pay_Dat    <= '0;
      Pay_Idx    <= '0;
      Pay_Vld    <= 1'b0;
      Frame_Len  <= '0;
      Frame_Done <= 1'b0;
      Err_Chk    <= 1'b0;
      Err_Len    <= 1'b0;
      Err_Tmo    <= 1'b0;
    end else begin
      // Alternate request cycles so a pop is never issued before the
      // FIFO's empty flag has reflected the previous one.
      RD_Req_sig <= !Empty_sig && !RD_Req_sig;
      cap        <= RD_Req_sig;

      Pay_Vld    <= 1'b0;
      Frame_Done <= 1'b0;
      Err_Chk    <= 1'b0;
      Err_Len    <= 1'b0;
      Err_Tmo    <= 1'b0;

      if (cap) begin
        // A byte landing on the expiry cycle takes priority over the timeout.
        tmo_cnt <= '0;
        unique case (state)
          S_HDR0: if (FIFO_RD_Dat == HDR0) state <= S_HDR1;
          S_HDR1: begin
            if (FIFO_RD_Dat == HDR1)      state <= S_LEN;
            else if (FIFO_RD_Dat != HDR0) state <= S_HDR0;
            // a repeated HDR0 keeps us waiting for HDR1
          end
          S_LEN: begin
            if (FIFO_RD_Dat == 8'd0 || FIFO_RD_Dat > MAX_LEN_B) begin
              Err_Len <= 1'b1;
              state   <= S_HDR0;
            end else begin
              len   <= FIFO_RD_Dat;
              sum   <= FIFO_RD_Dat;
              idx   <= '0;
              state <= S_PAY;
            end
          end
          S_PAY: begin
            Pay_Dat <= FIFO_RD_Dat;
            Pay_Idx <= idx;
            Pay_Vld <= 1'b1;
            sum     <= sum + FIFO_RD_Dat;
            idx     <= idx + 6'd1;
            if ({2'b00, idx} == len - 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (FIFO_RD_Dat == sum) begin
              Frame_Done <= 1'b1;
              Frame_Len  <= len;
            end else begin
              Err_Chk <= 1'b1;
            end
            state <= S_HDR0;
          end
          default: state <= S_HDR0;
        endcase
      end else if (state != S_HDR0) begin
        if (tmo_cnt == TMO_LAST) begin
          Err_Tmo <= 1'b1;
          tmo_cnt <= '0;
          state   <= S_HDR0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Downstream consumer of the UART RX FIFO. Pops bytes through the FIFO read port (RD_Req_sig / FIFO_RD_Dat / Empty_sig) and delineates framed packets.
- Frame format: HDR0, HDR1, LEN, LEN payload bytes, CHK.
- Emits payload bytes with their index, then a frame-done pulse or an error pulse.
- Feeds the command/telemetry decoder.

Parameters:
- HDR0, 8'hAA, first sync byte
- HDR1, 8'h55, second sync byte
- MAX_LEN, 32, largest legal LEN (1..63)
- TIMEOUT_CYC, 50000, idle cycles allowed between bytes inside a frame before abort

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- Empty_sig  in  1  RX FIFO empty
- FIFO_RD_Dat  in  8  RX FIFO read data, valid the cycle after RD_Req_sig
- RD_Req_sig  out  1  RX FIFO pop request, registered
- Pay_Dat  out  8  payload byte
- Pay_Idx  out  6  payload byte index, 0-based
- Pay_Vld  out  1  one-cycle strobe qualifying Pay_Dat/Pay_Idx
- Frame_Len  out  8  LEN of last good frame, held until the next Frame_Done
- Frame_Done  out  1  one-cycle pulse: frame received, checksum good
- Err_Chk  out  1  one-cycle pulse: checksum mismatch
- Err_Len  out  1  one-cycle pulse: LEN==0 or LEN>MAX_LEN
- Err_Tmo  out  1  one-cycle pulse: inter-byte timeout

Behaviour:
- Reset (async, RST=1): all outputs 0, FSM in S_HDR0, counters/accumulator cleared. Reset mid-frame discards the frame silently; no error pulse.
- FIFO read rule:
  - RD_Req_sig <= !Empty_sig && !RD_Req_sig (never high two consecutive cycles).
  - Byte captured internally the cycle after RD_Req_sig=1.
  - Max throughput 1 byte / 2 cycles. Never pops when Empty_sig=1, so the FIFO cannot underflow.
- Byte arrives in cycle N+1 for RD_Req_sig in N. All resulting outputs (Pay_Vld, Frame_Done, Err_*) are registered and high in N+2.
- FSM, evaluated per captured byte b:
  - S_HDR0: b==HDR0 -> S_HDR1; else stay.
  - S_HDR1: b==HDR1 -> S_LEN; b==HDR0 -> stay (resync); else -> S_HDR0.
  - S_LEN:
    - b==0 or b>MAX_LEN -> Err_Len pulse, -> S_HDR0.
    - Otherwise: latch len=b, sum=b, idx=0, -> S_PAY.
  - S_PAY:
    - Pay_Dat=b, Pay_Idx=idx, Pay_Vld pulse; sum+=b (mod 256); idx+=1.
    - When idx reaches len-1 on this byte -> S_CHK.
  - S_CHK:
    - b==sum -> Frame_Done pulse, Frame_Len<=len.
    - Otherwise -> Err_Chk pulse, Frame_Len unchanged.
    - Either way -> S_HDR0.
- Checksum: 8-bit wrap sum of LEN and payload bytes; header bytes excluded.
- Payload bytes stream out before validation. The consumer must discard buffered payload on Err_Chk or Err_Tmo.
- Timeout:
  - Counter runs only in S_HDR1/S_LEN/S_PAY/S_CHK and clears on every captured byte.
  - At TIMEOUT_CYC-1: Err_Tmo pulse, -> S_HDR0.
  - Held at 0 in S_HDR0.
  - If a byte capture and expiry fall in the same cycle, the byte wins: it is processed, no timeout.
- At most one of Frame_Done/Err_Chk/Err_Len/Err_Tmo is high in any cycle. Pay_Vld never coincides with them.
- Back-to-back frames: the byte after CHK is evaluated in S_HDR0 with no gap cycles.

Test Plan:
- FIFO preloaded AA 55 03 01 02 03 09 -> Pay_Vld x3 with (Idx,Dat)=(0,01),(1,02),(2,03); Frame_Done once; Frame_Len=3; RD_Req_sig never on consecutive cycles; 7 pops total.
- AA 55 03 01 02 03 0A -> 3 Pay_Vld, then Err_Chk pulse, no Frame_Done, Frame_Len keeps its previous value.
- 13 AA AA 55 02 FF 02 03 -> leading junk/duplicate header tolerated; Pay (0,FF),(1,02); sum 02+FF+02=0x03 wraps; Frame_Done, Frame_Len=2.
- AA 55 00 then AA 55 21 (MAX_LEN=32) -> two Err_Len pulses, no Pay_Vld; a following valid frame parses correctly.
- AA 55 04 11 then FIFO stays empty for TIMEOUT_CYC cycles (bench overrides TIMEOUT_CYC=20) -> one Err_Tmo exactly 20 cycles after the last captured byte, FSM back in S_HDR0; also a byte arriving on the expiry cycle -> no Err_Tmo.
- RST asserted mid-payload -> outputs 0 immediately (async), no error pulse; after release, AA 55 01 7E 7F -> Pay (0,7E), Frame_Done.
